// File: rtl/stack_controller.sv
// Stack sequencer: owns SP, splits PUSH/POP/CALL/RET/INT/RTI into one-word accesses.
// Optional feature: define STACK_BOUND_CHECK_EN to reject ops that would over/underflow the stack.
module stack_controller #(
    parameter logic [31:0] SP_INIT  = 32'h000F_FFFF,
    parameter logic [31:0] SP_LIMIT = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Op_Valid,
    input  logic [2:0]  Op_Code,
    input  logic [15:0] Push_Data,
    input  logic [31:0] Pc_In,
    input  logic [2:0]  Flags_In,
    output logic        Op_Ready,
    output logic        Stall,
    output logic [31:0] Mem_Addr,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic [15:0] Mem_Wdata,
    input  logic [15:0] Mem_Rdata,
    output logic [15:0] Pop_Data,
    output logic        Pop_Valid,
    output logic [31:0] Pc_Out,
    output logic        Pc_Valid,
    output logic [2:0]  Flags_Out,
    output logic        Flags_Valid,
    output logic [31:0] Sp_Out,
    output logic        Stack_Err
);

    typedef enum logic [2:0] {
        OP_NOP0 = 3'b000, OP_PUSH = 3'b001, OP_POP = 3'b010, OP_CALL = 3'b011,
        OP_RET  = 3'b100, OP_INT  = 3'b101, OP_RTI = 3'b110, OP_NOP7 = 3'b111
    } op_e;

    typedef enum logic {ST_IDLE, ST_XFER} state_e;

    state_e      state, state_nxt;
    op_e         op_in, op_q;
    logic [31:0] sp;
    logic [1:0]  cnt;
    logic        is_rd_q;
    logic [47:0] wr_sr;
    logic [18:0] rd_buf;
    logic [1:0]  n_words;
    logic        in_is_rd;
    logic        accept;
    logic        reject;
    logic        start;

    assign op_in  = op_e'(Op_Code);
    assign Sp_Out = sp;

    always_comb begin
        n_words  = 2'd0;
        in_is_rd = 1'b0;
        case (op_in)
            OP_PUSH: n_words = 2'd1;
            OP_POP:  begin n_words = 2'd1; in_is_rd = 1'b1; end
            OP_CALL: n_words = 2'd2;
            OP_RET:  begin n_words = 2'd2; in_is_rd = 1'b1; end
            OP_INT:  n_words = 2'd3;
            OP_RTI:  begin n_words = 2'd3; in_is_rd = 1'b1; end
            default: n_words = 2'd0;
        endcase
    end

`ifdef STACK_BOUND_CHECK_EN
    logic [31:0] depth;
    logic [31:0] headroom;
    assign depth    = SP_INIT - sp;
    assign headroom = sp - SP_LIMIT;
    // Pops need N filled slots above SP; pushes need the last write (SP-(N-1)) to stay >= SP_LIMIT.
    assign reject = (n_words != 2'd0) &&
                    (in_is_rd ? (depth < {30'b0, n_words})
                              : (headroom < ({30'b0, n_words} - 32'd1)));
`else
    assign reject = 1'b0;
`endif

    assign accept = Op_Valid && (state == ST_IDLE);
    assign start  = accept && (n_words != 2'd0) && !reject;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Op_Ready  = 1'b0;
        Stall     = 1'b0;
        Mem_Addr  = sp;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        Mem_Wdata = '0;
        case (state)
            ST_IDLE: begin
                Op_Ready = 1'b1;
                if (start) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                Stall = 1'b1;
                if (is_rd_q) begin
                    Mem_Read = 1'b1;
                    Mem_Addr = sp + 32'd1;
                end else begin
                    Mem_Write = 1'b1;
                    Mem_Wdata = wr_sr[47:32];
                end
                if (cnt == 2'd0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sp          <= SP_INIT;
            cnt         <= '0;
            is_rd_q     <= 1'b0;
            op_q        <= OP_NOP0;
            wr_sr       <= '0;
            rd_buf      <= '0;
            Pop_Data    <= '0;
            Pop_Valid   <= 1'b0;
            Pc_Out      <= '0;
            Pc_Valid    <= 1'b0;
            Flags_Out   <= '0;
            Flags_Valid <= 1'b0;
            Stack_Err   <= 1'b0;
        end else begin
            Pop_Valid   <= 1'b0;
            Pc_Valid    <= 1'b0;
            Flags_Valid <= 1'b0;
            Stack_Err   <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept && reject) Stack_Err <= 1'b1;
                if (start) begin
                    cnt     <= n_words - 2'd1;
                    is_rd_q <= in_is_rd;
                    op_q    <= op_in;
                    rd_buf  <= '0;
                    // Write words queued most-significant first; each access shifts the next into place.
                    case (op_in)
                        OP_PUSH: wr_sr <= {Push_Data, 32'h0};
                        OP_CALL: wr_sr <= {Pc_In, 16'h0};
                        OP_INT:  wr_sr <= {Pc_In, 13'b0, Flags_In};
                        default: wr_sr <= '0;
                    endcase
                end
            end else begin
                cnt   <= cnt - 2'd1;
                wr_sr <= {wr_sr[31:0], 16'h0};
                if (is_rd_q) begin
                    sp     <= sp + 32'd1;
                    rd_buf <= {rd_buf[2:0], Mem_Rdata};
                    if (cnt == 2'd0) begin
                        case (op_q)
                            OP_POP: begin
                                Pop_Data  <= Mem_Rdata;
                                Pop_Valid <= 1'b1;
                            end
                            OP_RET: begin
                                Pc_Out   <= {Mem_Rdata, rd_buf[15:0]};
                                Pc_Valid <= 1'b1;
                            end
                            OP_RTI: begin
                                Pc_Out      <= {Mem_Rdata, rd_buf[15:0]};
                                Pc_Valid    <= 1'b1;
                                Flags_Out   <= rd_buf[18:16];
                                Flags_Valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    sp <= sp - 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a small 16-word memory model on the stack port.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stack_controller;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Op_Valid = 1'b0;
    logic [2:0]  Op_Code = 3'b000;
    logic [15:0] Push_Data = '0;
    logic [31:0] Pc_In = '0;
    logic [2:0]  Flags_In = '0;
    logic        Op_Ready, Stall, Mem_Read, Mem_Write;
    logic [31:0] Mem_Addr, Pc_Out, Sp_Out;
    logic [15:0] Mem_Wdata, Mem_Rdata, Pop_Data;
    logic        Pop_Valid, Pc_Valid, Flags_Valid, Stack_Err;
    logic [2:0]  Flags_Out;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [79:0] got, exp;
    logic [15:0] mem [16];

    stack_controller dut (
        .Clk(Clk), .Rst(Rst), .Op_Valid(Op_Valid), .Op_Code(Op_Code),
        .Push_Data(Push_Data), .Pc_In(Pc_In), .Flags_In(Flags_In),
        .Op_Ready(Op_Ready), .Stall(Stall), .Mem_Addr(Mem_Addr),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Wdata(Mem_Wdata),
        .Mem_Rdata(Mem_Rdata), .Pop_Data(Pop_Data), .Pop_Valid(Pop_Valid),
        .Pc_Out(Pc_Out), .Pc_Valid(Pc_Valid), .Flags_Out(Flags_Out),
        .Flags_Valid(Flags_Valid), .Sp_Out(Sp_Out), .Stack_Err(Stack_Err)
    );

    always #5 Clk = ~Clk;

    assign Mem_Rdata = mem[Mem_Addr[3:0]];
    always @(posedge Clk) if (Mem_Write) mem[Mem_Addr[3:0]] <= Mem_Wdata;

    task automatic do_reset();
        @(negedge Clk); Rst = 1'b1; Op_Valid = 1'b0;
        @(negedge Clk); Rst = 1'b0;
    endtask

    task automatic request(input logic [2:0] op, input logic [15:0] pd,
                           input logic [31:0] pc, input logic [2:0] fl);
        Op_Valid = 1'b1; Op_Code = op; Push_Data = pd; Pc_In = pc; Flags_In = fl;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        got = {Op_Ready, Stall, Mem_Read, Mem_Write, Mem_Addr, Sp_Out, Mem_Wdata[9:0]};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'h000F_FFFF, 32'h000F_FFFF, 10'h0};
        total++; if (got !== exp) begin bad++; $display("FAIL reset_ctl got=%h exp=%h", got, exp); end
        got = {Pop_Valid, Pc_Valid, Flags_Valid, Stack_Err, Pop_Data, Pc_Out, Flags_Out, Mem_Wdata};
        exp = '0;
        total++; if (got !== exp) begin bad++; $display("FAIL reset_res got=%h exp=%h", got, exp); end
        Rst = 1'b0;
    endtask

    task automatic test_push_pop();
        do_reset();
        request(3'b001, 16'hBEEF, 32'h0, 3'b0);
        @(negedge Clk); Op_Valid = 1'b0; Push_Data = 16'h0000;
        got = {Stall, Op_Ready, Mem_Write, Mem_Read, Mem_Addr, Mem_Wdata, Sp_Out};
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 32'h000F_FFFF, 16'hBEEF, 32'h000F_FFFF};
        total++; if (got !== exp) begin bad++; $display("FAIL push_wr got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Stall, Op_Ready, Mem_Write, Mem_Read, Sp_Out, Mem_Addr};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 32'h000F_FFFE, 32'h000F_FFFE};
        total++; if (got !== exp) begin bad++; $display("FAIL push_done got=%h exp=%h", got, exp); end
        request(3'b010, 16'h0, 32'h0, 3'b0);
        @(negedge Clk); Op_Valid = 1'b0;
        got = {Stall, Mem_Write, Mem_Read, Mem_Addr, Mem_Wdata, Pop_Valid};
        exp = {1'b1, 1'b0, 1'b1, 32'h000F_FFFF, 16'h0, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL pop_rd got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Pop_Valid, Pop_Data, Sp_Out, Stall, Pc_Valid};
        exp = {1'b1, 16'hBEEF, 32'h000F_FFFF, 1'b0, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL pop_res got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Pop_Valid, Pop_Data};
        exp = {1'b0, 16'hBEEF};
        total++; if (got !== exp) begin bad++; $display("FAIL pop_pulse got=%h exp=%h", got, exp); end
    endtask

    task automatic test_call_ret();
        do_reset();
        request(3'b011, 16'h0, 32'h1234_5678, 3'b0);
        @(negedge Clk); Op_Valid = 1'b0; Pc_In = 32'hFFFF_FFFF;
        got = {Stall, Mem_Write, Mem_Addr, Mem_Wdata};
        exp = {1'b1, 1'b1, 32'h000F_FFFF, 16'h1234};
        total++; if (got !== exp) begin bad++; $display("FAIL call_w0 got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Stall, Mem_Write, Mem_Addr, Mem_Wdata};
        exp = {1'b1, 1'b1, 32'h000F_FFFE, 16'h5678};
        total++; if (got !== exp) begin bad++; $display("FAIL call_w1 got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Stall, Mem_Write, Sp_Out};
        exp = {1'b0, 1'b0, 32'h000F_FFFD};
        total++; if (got !== exp) begin bad++; $display("FAIL call_sp got=%h exp=%h", got, exp); end
        request(3'b100, 16'h0, 32'h0, 3'b0);
        @(negedge Clk); Op_Valid = 1'b0;
        got = {Mem_Read, Mem_Write, Mem_Addr};
        exp = {1'b1, 1'b0, 32'h000F_FFFE};
        total++; if (got !== exp) begin bad++; $display("FAIL ret_r0 got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Mem_Read, Mem_Addr, Pc_Valid};
        exp = {1'b1, 32'h000F_FFFF, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL ret_r1 got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Pc_Valid, Flags_Valid, Pop_Valid, Pc_Out, Sp_Out, Stall};
        exp = {1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h000F_FFFF, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL ret_res got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Pc_Valid};
        exp = {1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL ret_pulse got=%h exp=%h", got, exp); end
    endtask

    task automatic test_int_rti();
        logic [31:0] waddr [3];
        logic [15:0] wdat  [3];
        waddr = '{32'h000F_FFFF, 32'h000F_FFFE, 32'h000F_FFFD};
        wdat  = '{16'h0000, 16'h0100, 16'h0005};
        do_reset();
        request(3'b101, 16'h0, 32'h0000_0100, 3'b101);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); Op_Valid = 1'b0; Pc_In = 32'hDEAD_BEEF; Flags_In = 3'b010;
            got = {Mem_Write, Mem_Read, Mem_Addr, Mem_Wdata};
            exp = {1'b1, 1'b0, waddr[i], wdat[i]};
            total++; if (got !== exp) begin bad++; $display("FAIL int_w%0d got=%h exp=%h", i, got, exp); end
        end
        @(negedge Clk);
        got = {Stall, Sp_Out};
        exp = {1'b0, 32'h000F_FFFC};
        total++; if (got !== exp) begin bad++; $display("FAIL int_sp got=%h exp=%h", got, exp); end
        request(3'b110, 16'h0, 32'h0, 3'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); Op_Valid = 1'b0;
            got = {Mem_Read, Mem_Write, Mem_Addr};
            exp = {1'b1, 1'b0, waddr[2 - i]};
            total++; if (got !== exp) begin bad++; $display("FAIL rti_r%0d got=%h exp=%h", i, got, exp); end
        end
        @(negedge Clk);
        got = {Pc_Valid, Flags_Valid, Flags_Out, Pc_Out, Sp_Out};
        exp = {1'b1, 1'b1, 3'b101, 32'h0000_0100, 32'h000F_FFFF};
        total++; if (got !== exp) begin bad++; $display("FAIL rti_res got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        request(3'b001, 16'hA5A5, 32'h0, 3'b0);
        @(negedge Clk); Op_Code = 3'b010;
        got = {Mem_Write, Mem_Addr, Mem_Wdata};
        exp = {1'b1, 32'h000F_FFFF, 16'hA5A5};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_push got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Op_Ready, Stall, Sp_Out};
        exp = {1'b1, 1'b0, 32'h000F_FFFE};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_idle got=%h exp=%h", got, exp); end
        @(negedge Clk); Op_Valid = 1'b0;
        got = {Mem_Read, Mem_Addr};
        exp = {1'b1, 32'h000F_FFFF};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_pop got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Pop_Valid, Pop_Data, Op_Ready};
        exp = {1'b1, 16'hA5A5, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_popres got=%h exp=%h", got, exp); end
        request(3'b001, 16'h1111, 32'h0, 3'b0);
        @(negedge Clk); Op_Valid = 1'b0;
        got = {Mem_Write, Mem_Addr, Mem_Wdata, Pop_Valid};
        exp = {1'b1, 32'h000F_FFFF, 16'h1111, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_onpulse got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Sp_Out};
        exp = {32'h000F_FFFE};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_sp got=%h exp=%h", got, exp); end
    endtask

    task automatic test_nop();
        logic [2:0] nops [2];
        nops = '{3'b000, 3'b111};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            request(nops[i], 16'hFFFF, 32'hFFFF_FFFF, 3'b111);
            @(negedge Clk); Op_Valid = 1'b0;
            got = {Op_Ready, Stall, Mem_Read, Mem_Write, Sp_Out, Stack_Err};
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'h000F_FFFF, 1'b0};
            total++; if (got !== exp) begin bad++; $display("FAIL nop%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_reset_mid_call();
        do_reset();
        request(3'b011, 16'h0, 32'hAAAA_5555, 3'b0);
        @(negedge Clk); Op_Valid = 1'b0;
        got = {Mem_Write, Mem_Wdata};
        exp = {1'b1, 16'hAAAA};
        total++; if (got !== exp) begin bad++; $display("FAIL midrst_w0 got=%h exp=%h", got, exp); end
        @(negedge Clk); Rst = 1'b1;
        #1;
        got = {Stall, Op_Ready, Mem_Write, Mem_Read, Sp_Out, Mem_Addr};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 32'h000F_FFFF, 32'h000F_FFFF};
        total++; if (got !== exp) begin bad++; $display("FAIL midrst got=%h exp=%h", got, exp); end
        @(negedge Clk); Rst = 1'b0;
    endtask

    task automatic test_ret_empty();
        do_reset();
        request(3'b100, 16'h0, 32'h0, 3'b0);
`ifdef STACK_BOUND_CHECK_EN
        @(negedge Clk); Op_Valid = 1'b0;
        got = {Stack_Err, Stall, Mem_Read, Sp_Out, Pc_Valid};
        exp = {1'b1, 1'b0, 1'b0, 32'h000F_FFFF, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL bound_err got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Stack_Err, Stall, Mem_Read, Sp_Out, Pc_Valid};
        exp = {1'b0, 1'b0, 1'b0, 32'h000F_FFFF, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL bound_after got=%h exp=%h", got, exp); end
`else
        @(negedge Clk); Op_Valid = 1'b0;
        got = {Mem_Read, Mem_Addr, Stack_Err};
        exp = {1'b1, 32'h0010_0000, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL wrap_r0 got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Mem_Read, Mem_Addr, Stack_Err};
        exp = {1'b1, 32'h0010_0001, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL wrap_r1 got=%h exp=%h", got, exp); end
        @(negedge Clk);
        got = {Sp_Out, Pc_Valid, Stall, Stack_Err};
        exp = {32'h0010_0001, 1'b1, 1'b0, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL wrap_sp got=%h exp=%h", got, exp); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        test_reset();
        test_push_pop();
        test_call_ret();
        test_int_rti();
        test_back_to_back();
        test_nop();
        test_reset_mid_call();
        test_ret_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
# stack_controller

Multi-cycle sequencer owning the core's 32-bit stack pointer and the stack's share of the 16-bit data-memory port. It accepts one stack operation at a time from decode (PUSH, POP, CALL, RET, INT, RTI), breaks it into one-word memory accesses, and steps SP by one per access. It stalls the pipeline while busy and returns popped data, PC and flags with single-cycle valid pulses.

## Interface
- SP_INIT, 32'h000F_FFFF: SP value at reset; highest stack address; stack grows downward.
- SP_LIMIT, 32'h0000_0000: lowest legal stack address (bound checking only).
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Op_Valid  in  1  operation request.
- Op_Code  in  3  000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 INT, 110 RTI, 111 NOP.
- Push_Data  in  16  PUSH word.
- Pc_In  in  32  return PC for CALL/INT.
- Flags_In  in  3  flags for INT.
- Op_Ready  out  1  high in IDLE; request accepted on edge where Op_Valid & Op_Ready.
- Stall  out  1  high whenever state != IDLE.
- Mem_Addr  out  32  stack access address.
- Mem_Read / Mem_Write  out  1  access strobes, mutually exclusive.
- Mem_Wdata  out  16  write data.
- Mem_Rdata  in  16  read data, combinational, sampled at the edge ending a read cycle.
- Pop_Data / Pop_Valid  out  16 / 1  POP result, one-cycle pulse.
- Pc_Out / Pc_Valid  out  32 / 1  RET/RTI result, one-cycle pulse.
- Flags_Out / Flags_Valid  out  3 / 1  RTI result, one-cycle pulse.
- Sp_Out  out  32  current SP register.
- Stack_Err  out  1  one-cycle pulse on rejected op.

## Operation
- SP points to next free slot. Write: address SP, then SP-1. Read: SP+1, address SP+1.
- Word counts: PUSH/POP 1, CALL/RET 2, INT/RTI 3; NOP accepted, no access, stays IDLE.
- Write order: CALL → Pc_In[31:16], Pc_In[15:0]; INT → Pc_In[31:16], Pc_In[15:0], {13'b0, Flags_In}.
- Read order (exact reverse): RET → PC low, PC high; RTI → flags (bits [2:0]), PC low, PC high.
- Operands (Op_Code, Push_Data, Pc_In, Flags_In) latched at acceptance; later input changes ignored.
- FSM: IDLE → XFER (word counter = N-1) on accept; XFER does one access per cycle, counter decrements, SP ±1 per edge; counter 0 at edge → IDLE.
- Result registers and valid pulses are loaded at the edge ending the final read; valid high for exactly the following cycle, which is an IDLE cycle (a new op may be accepted in it).
- Outside XFER: Mem_Read=Mem_Write=0, Mem_Addr=SP, Mem_Wdata=0.

## Timing
- Reset (async, immediate, also mid-op): state IDLE, SP=SP_INIT, Op_Ready=1, Stall=0, all strobes/valids/Stack_Err=0, Pop_Data=Pc_Out=Flags_Out=0, Mem_Addr=SP_INIT. Partially written stack contents are not restored.
- Op occupies 1 accept cycle + N access cycles; Op_Ready low for N cycles. PUSH: SP updated 2 edges after accept-cycle start.
- Back-to-back: op requested in the cycle a valid pulse is high is accepted.

## Configuration
- STACK_BOUND_CHECK_EN defined: at acceptance, pop-type op rejected if SP_INIT - SP < N; push-type rejected if SP - SP_LIMIT < N-1 (i.e. last write below SP_LIMIT). Rejection: Stack_Err pulses next cycle, no memory access, SP unchanged, no valids, stays IDLE, Stall never asserts.
- Undefined: no checks, SP wraps modulo 2^32, Stack_Err tied 0.

## Test plan
- Reset mid-CALL (after first write) → same cycle Stall=0, Sp_Out=000F_FFFF, Mem_Write=0.
- PUSH 16'hBEEF from reset → one write at 000F_FFFF, Sp_Out=000F_FFFE; POP → read at 000F_FFFF, Pop_Data=BEEF, Pop_Valid one cycle, Sp_Out=000F_FFFF.
- CALL Pc_In=1234_5678 → writes 1234@000F_FFFF, 5678@000F_FFFE, Stall high 2 cycles; RET → Pc_Out=1234_5678, Pc_Valid one cycle, SP restored.
- INT Pc_In=0000_0100, Flags_In=3'b101 → 3 writes ending with 0005@000F_FFFD, SP=000F_FFFC; RTI → Flags_Out=101, Pc_Out=0000_0100, both valids same cycle.
- Op_Valid held high with POP immediately after a PUSH completes → accepted in the first IDLE cycle, no lost cycle.
- With STACK_BOUND_CHECK_EN: RET at SP=SP_INIT → Stack_Err pulse, no Mem_Read, SP unchanged; without: reads 0010_0000, 0010_0001, SP=0010_0001.
